// File: rtl/user_pb_pkg.sv
// user_pb_pkg: state encoding and parameter defaults shared by the pushbutton debouncer
package user_pb_pkg;
   typedef enum logic [1:0] {
      REL_STABLE = 2'd0,
      PRESS_PEND = 2'd1,
      PRS_STABLE = 2'd2,
      REL_PEND   = 2'd3
   } pb_state_t;
   localparam int TICK_DIV_DEF   = 50000;
   localparam int DB_TICKS_DEF   = 10;
   localparam int LONG_TICKS_DEF = 1000;
endpackage

// File: rtl/user_pb_cell.sv
// user_pb_cell: one button -- synchroniser, debounce FSM and registered level/press/release/long outputs (long-press logic under USER_PB_LONGPRESS_EN)
module user_pb_cell
   import user_pb_pkg::*;
#(
   parameter int DB_TICKS   = DB_TICKS_DEF,
   parameter int LONG_TICKS = LONG_TICKS_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic pb_ni,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);
   localparam int DBW = $clog2(DB_TICKS + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);
   localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_TICKS);

   logic s1_q, s2_q, s;
   pb_state_t state_q, state_d;
   logic [DBW-1:0] db_cnt_q, db_cnt_d, db_inc;
   logic level_q, level_d, press_q, press_d, release_q, release_d;

   // two-flop synchroniser, reset to the released (high) pin level
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) {s1_q, s2_q} <= 2'b11;
      else {s1_q, s2_q} <= {pb_ni, s1_q};

   assign s      = ~s2_q;
   assign db_inc = (db_cnt_q == DB_MAX) ? db_cnt_q : DBW'(db_cnt_q + 1);

   // state, debounce counter and registered commit outputs
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= REL_STABLE;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end

   // next state: a pending state commits on its DB_TICKS-th tick and falls back on any disagreeing sample
   always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      unique case (state_q)
         REL_STABLE: if (s) begin
            state_d  = PRESS_PEND;
            db_cnt_d = '0;
         end
         PRESS_PEND: if (!s) begin
            state_d  = REL_STABLE;
            db_cnt_d = '0;
         end else if (tick_i) begin
            state_d  = (db_cnt_q == DB_LAST) ? PRS_STABLE : PRESS_PEND;
            db_cnt_d = (db_cnt_q == DB_LAST) ? '0 : db_inc;
         end
         PRS_STABLE: if (!s) begin
            state_d  = REL_PEND;
            db_cnt_d = '0;
         end
         REL_PEND: if (s) begin
            state_d  = PRS_STABLE;
            db_cnt_d = '0;
         end else if (tick_i) begin
            state_d  = (db_cnt_q == DB_LAST) ? REL_STABLE : REL_PEND;
            db_cnt_d = (db_cnt_q == DB_LAST) ? '0 : db_inc;
         end
      endcase
   end

   // outputs: pulses only on a genuine commit, never on a bounce back to the stable state
   always_comb begin
      press_d   = state_q == PRESS_PEND && state_d == PRS_STABLE;
      release_d = state_q == REL_PEND && state_d == REL_STABLE;
      level_d   = state_d == PRS_STABLE || state_d == REL_PEND;
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

`ifdef USER_PB_LONGPRESS_EN
   localparam int LW = $clog2(LONG_TICKS + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

   logic [LW-1:0] long_cnt_q, long_cnt_d;
   logic long_q, long_d, held;

   // long-press counter runs while pressed, restarts on a new press and saturates so it fires once
   always_comb begin
      held       = state_q == PRS_STABLE || state_q == REL_PEND;
      long_cnt_d = (press_d || state_d == REL_STABLE) ? '0 :
                   (held && tick_i && long_cnt_q != LONG_MAX) ? LW'(long_cnt_q + 1) : long_cnt_q;
      long_d     = long_cnt_d == LONG_MAX && long_cnt_q != LONG_MAX;
   end

   // long-press counter and pulse registers
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         long_q     <= long_d;
      end

   assign long_o = long_q;
`else
   logic unused_long;
   assign unused_long = ^LONG_TICKS;
   assign long_o      = 1'b0;
`endif
endmodule

// File: rtl/user_pb_debounce.sv
// user_pb_debounce: debounces the active-low USER_PB pins with a shared tick prescaler; define USER_PB_LONGPRESS_EN for pb_long
module user_pb_debounce
   import user_pb_pkg::*;
#(
   parameter int PB_W       = 4,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int DB_TICKS   = DB_TICKS_DEF,
   parameter int LONG_TICKS = LONG_TICKS_DEF
) (
   input  logic            OSC_50m,
   input  logic            FPGA_RSTn,
   input  logic [PB_W-1:0] USER_PB,
   output logic [PB_W-1:0] pb_level,
   output logic [PB_W-1:0] pb_press,
   output logic [PB_W-1:0] pb_release,
   output logic [PB_W-1:0] pb_long
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic tick;

   assign tick  = pre_q == PRE_LAST;
   assign pre_d = tick ? '0 : PW'(pre_q + 1);

   // free-running prescaler producing one tick every TICK_DIV clocks
   always_ff @(posedge OSC_50m or negedge FPGA_RSTn)
      if (!FPGA_RSTn) pre_q <= '0;
      else pre_q <= pre_d;

   for (genvar i = 0; i < PB_W; i++) begin : g_cell
      user_pb_cell #(
         .DB_TICKS  (DB_TICKS),
         .LONG_TICKS(LONG_TICKS)
      ) u_cell (
         .clk_i    (OSC_50m),
         .rst_ni   (FPGA_RSTn),
         .tick_i   (tick),
         .pb_ni    (USER_PB[i]),
         .level_o  (pb_level[i]),
         .press_o  (pb_press[i]),
         .release_o(pb_release[i]),
         .long_o   (pb_long[i])
      );
   end
endmodule

// File: tb/tb_user_pb_debounce.sv
// tb_user_pb_debounce: directed pushbutton scenarios with an expected-event queue checked by a pulse monitor
module tb_user_pb_debounce;
   localparam int PB_W       = 4;
   localparam int TICK_DIV   = 4;
   localparam int DB_TICKS   = 3;
   localparam int LONG_TICKS = 8;

   typedef struct {
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lng;
      logic [3:0] lvl;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [PB_W-1:0] pb = 4'b1110;
   logic [PB_W-1:0] pb_level, pb_press, pb_release, pb_long;
   ev_t q[$];
   ev_t mon_e;
   int cyc;
   int checks = 0;
   int errors = 0;
   logic [3:0] exp_lvl = 4'b0000;

   user_pb_debounce #(
      .PB_W      (PB_W),
      .TICK_DIV  (TICK_DIV),
      .DB_TICKS  (DB_TICKS),
      .LONG_TICKS(LONG_TICKS)
   ) dut (
      .OSC_50m   (clk),
      .FPGA_RSTn (rst_n),
      .USER_PB   (pb),
      .pb_level  (pb_level),
      .pb_press  (pb_press),
      .pb_release(pb_release),
      .pb_long   (pb_long)
   );

   always #5 clk = ~clk;

   // clock edges since the last reset release; ticks act on edges that are multiples of TICK_DIV
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;

   // pin changed just after edge k: synchroniser gives entry at k+3, commit on the DB_TICKS-th tick after that
   function automatic int commit_at(input int k);
      int e, t1;
      e  = k + 3;
      t1 = (e / TICK_DIV + 1) * TICK_DIV;
      return t1 + TICK_DIV * (DB_TICKS - 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l, input int c);
      exp_lvl = (exp_lvl | p) & ~r;
      q.push_back('{p, r, l, exp_lvl, c});
   endtask

   task automatic set_pb(input logic [3:0] v, output int k);
      @(negedge clk);
      pb = v;
      k  = cyc;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk)
      if (rst_n && (pb_press | pb_release | pb_long) != 4'b0000) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse cyc %0d press %b release %b long %b", cyc, pb_press, pb_release, pb_long);
         end else begin
            mon_e = q.pop_front();
            chk("ev_press", pb_press, mon_e.press);
            chk("ev_release", pb_release, mon_e.rel);
            chk("ev_long", pb_long, mon_e.lng);
            chk("ev_level", pb_level, mon_e.lvl);
            chk("ev_cycle", cyc, mon_e.cyc);
         end
      end

   initial begin
      int k, c;
      // button 0 held through reset
      wait_clk(3);
      chk("rst_level", pb_level, 4'b0000);
      chk("rst_press", pb_press, 4'b0000);
      chk("rst_release", pb_release, 4'b0000);
      chk("rst_long", pb_long, 4'b0000);
      rst_n = 1'b1;
      expect_ev(4'b0001, 4'b0000, 4'b0000, commit_at(0));
      wait_clk(20);
      chk("lvl_after_rst", pb_level, 4'b0001);
      // clean press and release of button 1
      set_pb(4'b1100, k);
      expect_ev(4'b0010, 4'b0000, 4'b0000, commit_at(k));
      wait_clk(40);
      chk("lvl_press1", pb_level, 4'b0011);
      set_pb(4'b1110, k);
      expect_ev(4'b0000, 4'b0010, 4'b0000, commit_at(k));
      wait_clk(40);
      chk("lvl_release1", pb_level, 4'b0001);
      // bounce on button 2, then held pressed
      for (int i = 0; i < 10; i++) begin
         set_pb((i % 2 == 0) ? 4'b1010 : 4'b1110, k);
         wait_clk(2);
      end
      set_pb(4'b1010, k);
      expect_ev(4'b0100, 4'b0000, 4'b0000, commit_at(k));
      wait_clk(40);
      chk("lvl_bounce2", pb_level, 4'b0101);
      // 7-clock glitch on button 3
      set_pb(4'b0010, k);
      wait_clk(6);
      set_pb(4'b1010, k);
      wait_clk(30);
      chk("lvl_glitch3", pb_level, 4'b0101);
      // reset while button 3 is pending
      set_pb(4'b0010, k);
      wait_clk(5);
      rst_n   = 1'b0;
      pb      = 4'b1111;
      exp_lvl = 4'b0000;
      #1;
      chk("midrst_level", pb_level, 4'b0000);
      chk("midrst_press", pb_press, 4'b0000);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(40);
      chk("lvl_after_midrst", pb_level, 4'b0000);
      // simultaneous press of button 0 and release of button 1
      set_pb(4'b1101, k);
      expect_ev(4'b0010, 4'b0000, 4'b0000, commit_at(k));
      wait_clk(40);
      set_pb(4'b1110, k);
      c = commit_at(k);
      expect_ev(4'b0001, 4'b0010, 4'b0000, c);
`ifdef USER_PB_LONGPRESS_EN
      expect_ev(4'b0000, 4'b0000, 4'b0001, c + TICK_DIV * LONG_TICKS);
`endif
      while (cyc < c + TICK_DIV * (LONG_TICKS + 40)) @(negedge clk);
      chk("lvl_long_hold", pb_level, 4'b0001);
      set_pb(4'b1111, k);
      expect_ev(4'b0000, 4'b0001, 4'b0000, commit_at(k));
      wait_clk(40);
      // short hold of button 0: no long pulse
      set_pb(4'b1110, k);
      c = commit_at(k);
      expect_ev(4'b0001, 4'b0000, 4'b0000, c);
      while (cyc < c + 12) @(negedge clk);
      pb = 4'b1111;
      expect_ev(4'b0000, 4'b0001, 4'b0000, commit_at(cyc));
      wait_clk(60);
      chk("pending_events", q.size(), 0);
      chk("lvl_final", pb_level, 4'b0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
